// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, hazard unit and IF/ID register.
interface if_fetch_stage_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          LE;
    logic          Branch_Taken;
    logic [AW-1:0] Target_Addr;
    logic          Squash_Delay;
    logic [DW-1:0] Inst_Mem_Data;
    logic [AW-1:0] Inst_Mem_Addr;
    logic [DW-1:0] Inst_out;
    logic [AW-1:0] PC_Front_out;
    logic [AW-1:0] PC_Back_out;
    logic          Valid_out;
    logic [CW-1:0] Fetch_Count;

    modport master (
        output LE, Branch_Taken, Target_Addr, Squash_Delay, Inst_Mem_Data,
        input  Inst_Mem_Addr, Inst_out, PC_Front_out, PC_Back_out, Valid_out, Fetch_Count
    );

    modport slave (
        input  LE, Branch_Taken, Target_Addr, Squash_Delay, Inst_Mem_Data,
        output Inst_Mem_Addr, Inst_out, PC_Front_out, PC_Back_out, Valid_out, Fetch_Count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// PA-RISC instruction-fetch stage: PC front/back queue with delayed branching,
// optional delay-slot squash, stall hold with captured redirects, and a fetch counter.
module if_fetch_stage #(
    parameter logic [7:0] RESET_PCF = 8'd0
) (
    input  logic             clk,
    input  logic             Reset,
    if_fetch_stage_if.slave  bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [AW-1:0] ALIGN_MASK = AW'(8'hFC);
    localparam logic [CW-1:0] CNT_MAX    = CW'(16'hFFFF);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pcf_q, pcf_d;
    logic [AW-1:0] pcb_q, pcb_d;
    logic          squash_q, squash_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          pend_sq_q, pend_sq_d;
    logic [CW-1:0] fetch_cnt_q, fetch_cnt_d;

    logic          running_c;
    logic          advance_c;
    logic          redirect_c;
    logic [AW-1:0] redir_tgt_c;
    logic          redir_sq_c;
    logic          valid_c;
    logic [DW-1:0] inst_c;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= BOOT;
            pcf_q       <= RESET_PCF;
            pcb_q       <= RESET_PCF + AW'(4);
            squash_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
            pend_sq_q   <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            pcb_q       <= pcb_d;
            squash_q    <= squash_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_sq_q   <= pend_sq_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // BOOT always leaves after one cycle; afterwards LE picks RUN vs HOLD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:      state_d = RUN;
            RUN, HOLD: state_d = bus.LE ? RUN : HOLD;
            default:   state_d = BOOT;
        endcase
    end

    // A live redirect takes priority over one captured during a stall.
    always_comb begin
        running_c   = (state_q != BOOT);
        advance_c   = running_c && bus.LE;
        redirect_c  = bus.Branch_Taken || pend_q;
        redir_tgt_c = bus.Branch_Taken ? (bus.Target_Addr & ALIGN_MASK) : pend_tgt_q;
        redir_sq_c  = bus.Branch_Taken ? bus.Squash_Delay : pend_sq_q;

        pcf_d       = pcf_q;
        pcb_d       = pcb_q;
        squash_d    = squash_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        pend_sq_d   = pend_sq_q;
        fetch_cnt_d = fetch_cnt_q;

        if (advance_c) begin
            pcf_d    = pcb_q;
            pcb_d    = redirect_c ? redir_tgt_c : pcb_q + AW'(4);
            squash_d = redirect_c && redir_sq_c;
            pend_d   = 1'b0;
            if (valid_c && (fetch_cnt_q != CNT_MAX))
                fetch_cnt_d = fetch_cnt_q + CW'(1);
        end else if (running_c && bus.Branch_Taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = bus.Target_Addr & ALIGN_MASK;
            pend_sq_d  = bus.Squash_Delay;
        end
    end

    always_comb begin
        valid_c = (state_q != BOOT) && !squash_q;
        inst_c  = valid_c ? bus.Inst_Mem_Data : '0;
    end

    assign bus.Inst_Mem_Addr = pcf_q;
    assign bus.PC_Front_out  = pcf_q;
    assign bus.PC_Back_out   = pcb_q;
    assign bus.Valid_out     = valid_c;
    assign bus.Inst_out      = inst_c;
    assign bus.Fetch_Count   = fetch_cnt_q;
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the PA-RISC pipeline: holds the PC front/back queue, drives the instruction-memory address, and presents the fetched word and its PC-front to the IF/ID register one stage downstream. It implements PA-RISC delayed branching (the instruction after a taken branch always occupies the pipeline), optional delay-slot squashing, and stall hold. A redirect that arrives during a stall is captured so it is not lost. It also maintains a saturating fetch counter for performance checks.

## Interface

- RESET_PCF, 8'd0, PC-front value loaded on reset.
- clk  in  1  pipeline clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high; dominates every other input.
- LE  in  1  stage advance enable from hazard unit; 0 = stall. Tied to the same signal as the IF/ID LE.
- Branch_Taken  in  1  redirect request from the resolving stage.
- Target_Addr  in  8  redirect target; bits [1:0] ignored and forced to 0.
- Squash_Delay  in  1  sampled with Branch_Taken; 1 = nullify the delay-slot instruction.
- Inst_Mem_Data  in  32  combinational read data for Inst_Mem_Addr.
- Inst_Mem_Addr  out  8  equals PCF, combinational.
- Inst_out  out  32  to IF/ID Inst_in; 32'b0 when not valid.
- PC_Front_out  out  8  to IF/ID PC_Front; equals PCF.
- PC_Back_out  out  8  equals PCB.
- Valid_out  out  1  Inst_out carries a real, non-squashed instruction.
- Fetch_Count  out  16  count of valid instructions advanced, saturating.

## Operation

- Registers: PCF, PCB (8 bit), state {BOOT, RUN, HOLD}, squash flag, pending flag, pending target (8), pending squash, Fetch_Count.
- Reset values: PCF=RESET_PCF, PCB=RESET_PCF+4, state=BOOT, squash=0, pending=0, Fetch_Count=0.
- Reset outputs: Inst_out=0, Valid_out=0, PC_Front_out=RESET_PCF, PC_Back_out=RESET_PCF+4.
- BOOT: outputs are a bubble (Inst_out=0, Valid_out=0). The PCs are frozen. The next state is always RUN, regardless of LE.
  - Branch_Taken during BOOT is ignored.
- Advance (state RUN or HOLD, LE=1):
  - PCF <= PCB.
  - PCB <= redirect ? {target[7:2],2'b00} : PCB+4.
  - The redirect source is the current Branch_Taken if asserted; otherwise the pending target if the pending flag is set. Current inputs win over pending.
  - The pending flag clears on any advance.
  - squash <= redirect's squash bit.
  - Next state is RUN.
- Hold (state RUN or HOLD, LE=0):
  - PCF, PCB and squash are unchanged; next state is HOLD.
  - Branch_Taken=1 sets pending and loads the pending target and pending squash. A later request overwrites an earlier one.
- Valid_out = (state != BOOT) & ~squash.
- Inst_out = Valid_out ? Inst_Mem_Data : 32'b0.
- Fetch_Count increments on each advance edge where Valid_out=1. It holds at 16'hFFFF.
- PC arithmetic is modulo 256: PCB=8'hFC advances to 8'h00.

## Timing

- Inst_Mem_Addr, Inst_out and Valid_out are combinational from registered state plus Inst_Mem_Data. The memory read is zero-latency; IF/ID captures at the next edge.
- Delayed branch: Branch_Taken at edge T with LE=1 gives:
  - cycle T+1: PCF = old PCB (the delay slot), PCB = target.
  - cycle T+2: PCF = target.
- Squash: the delay slot in cycle T+1 is output as 0 with Valid_out=0. The squash flag clears at the next advance edge and survives stalls.
- Stalled redirect: a request captured while LE=0 is applied on the first LE=1 edge, with identical T+1/T+2 behaviour.
- Reset asserted mid-stall or mid-redirect discards the pending and squash state and returns to BOOT on the next edge.

## Test plan

- Reset, then LE=1 with no branches:
  - BOOT cycle: Inst_out=0, Valid_out=0, PCF=0.
  - Following cycles: PCF=0,4,8,12 and Inst_out = memory word at each address.
  - Fetch_Count=3 after the third valid advance.
- Branch_Taken=1, Target_Addr=8'h40, Squash_Delay=0 while PCF=8, PCB=12:
  - next cycle: PCF=12, valid.
  - cycle after: PCF=8'h40, PCB=8'h44.
- Same branch with Squash_Delay=1:
  - PCF=12 cycle shows Inst_out=0, Valid_out=0, and Fetch_Count does not increment for it.
  - PCF=8'h40 is valid.
- LE=0 for 3 cycles:
  - PCs are frozen.
  - Branch_Taken pulse to 8'h80 in the second stall cycle; on LE=1, PCF=old PCB, then PCF=8'h80.
  - A second pulse to 8'h90 during the same stall overrides, giving 8'h90.
- Wrap and misalignment:
  - From PCF=8'hF8, sequence is F8, FC, 00.
  - Target_Addr=8'h43 is taken as 8'h40.
- Reset asserted while pending=1 and squash=1:
  - Returns to PCF=0, BOOT bubble, pending cleared, Fetch_Count=0.
  - Preload Fetch_Count near 16'hFFFF via a long run and confirm it saturates.
